// File: rtl/control_unit.sv
// Three-cycle FETCH/DECODE/EXECUTE sequencer that drives program_counter and
// the datapath write strobes from the instruction register.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       zero_flag,
  output logic       halt,
  output logic       branch_enable,
  output logic [3:0] branch_address,
  output logic [2:0] alu_op,
  output logic [3:0] imm,
  output logic       reg_we,
  output logic       mem_we,
  output logic [7:0] ir,
  output logic [2:0] state,
  output logic [7:0] retired,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_LDI   = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_JNZ   = 4'hA;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] opcode;
  logic       load_ir;
  logic       retire;
  logic       is_illegal;
  logic       writes_reg;

  assign opcode         = ir[7:4];
  assign imm            = ir[3:0];
  assign branch_address = ir[3:0];
  assign state          = state_q;

  // Operand decode is state-independent; only the strobes are gated by EXECUTE.
  always_comb begin
    alu_op     = 3'd0;
    writes_reg = 1'b0;
    is_illegal = 1'b0;
    if (opcode >= OP_ADD && opcode <= OP_XOR) begin
      alu_op     = 3'(opcode - OP_ADD);
      writes_reg = 1'b1;
    end else if (opcode == OP_LDI) begin
      alu_op     = 3'd5;
      writes_reg = 1'b1;
    end else if (opcode > OP_JNZ && opcode < OP_HLT) begin
      is_illegal = 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    halt          = 1'b1;
    branch_enable = 1'b0;
    reg_we        = 1'b0;
    mem_we        = 1'b0;
    load_ir       = 1'b0;
    retire        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        load_ir = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        retire = 1'b1;
        halt   = (opcode == OP_HLT);
        reg_we = writes_reg;
        mem_we = (opcode == OP_STORE);
        unique case (opcode)
          OP_JMP:  branch_enable = 1'b1;
          OP_JZ:   branch_enable = zero_flag;
          OP_JNZ:  branch_enable = ~zero_flag;
          default: branch_enable = 1'b0;
        endcase
        state_d = (opcode == OP_HLT) ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir      <= 8'h00;
      retired <= 8'd0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_ir) ir <= instr;
      if (retire) begin
        retired <= retired + 8'd1;
        if (is_illegal) illegal <= 1'b1;
      end
    end
  end

endmodule
